// File: rtl/trace_dump_ctrl_if.sv
// rtl/trace_dump_ctrl_if.sv - Wishbone master and host byte-stream signals of the trace dump controller
interface trace_dump_ctrl_if;
  logic [11:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output tx_data_o, tx_valid_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, tx_ready_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  tx_data_o, tx_valid_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, tx_ready_i
  );
endinterface

// File: rtl/trace_dump_ctrl.sv
// rtl/trace_dump_ctrl.sv - arms a trace logger trigger, waits for capture, dumps the log as bytes
module trace_dump_ctrl #(
  parameter int CAPT_WAIT = 1030,
  parameter int NWORDS    = 4096
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [31:0]         trig_val_i,
  input  logic [31:0]         trig0_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  trace_dump_ctrl_if.master   bus
);

  localparam int          CW       = $clog2(CAPT_WAIT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(CAPT_WAIT - 1);
  localparam logic [11:0] LAST_IDX = 12'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_TRIG, S_WAIT_CAPT, S_RD, S_SEND, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   trig_q, trig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   idx_q, idx_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic          err_q, err_d;

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      trig_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; abort overrides every handshake, bus error overrides ack
  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    err_d   = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            trig_d  = trig_val_i;
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          if (bus.wbm_err_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (bus.wbm_ack_i) begin
            state_d = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (trig0_i == trig_q) begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT_CAPT;
          end
        end
        S_WAIT_CAPT: begin
          if (cnt_q == '0) begin
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_RD: begin
          if (bus.wbm_err_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (bus.wbm_ack_i) begin
            shift_d = bus.wbm_dat_i;
            bcnt_d  = 2'd0;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          if (bus.tx_ready_i) begin
            // Low byte is always the one on the stream; shift the next one down
            shift_d = shift_q >> 8;
            if (bcnt_q == 2'd3) begin
              if (idx_q == LAST_IDX) begin
                state_d = S_FIN;
              end else begin
                idx_d   = idx_q + 12'd1;
                state_d = S_RD;
              end
            end else begin
              bcnt_d = bcnt_q + 2'd1;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state so reset clears them at once
  always_comb begin
    bus.wbm_cyc_o  = (state_q == S_ARM) || (state_q == S_RD);
    bus.wbm_stb_o  = bus.wbm_cyc_o;
    bus.wbm_we_o   = (state_q == S_ARM);
    bus.wbm_sel_o  = bus.wbm_cyc_o ? 4'hF : 4'h0;
    bus.wbm_adr_o  = (state_q == S_RD) ? idx_q : 12'd0;
    bus.wbm_dat_o  = (state_q == S_ARM) ? trig_q : 32'd0;
    bus.tx_valid_o = (state_q == S_SEND);
    bus.tx_data_o  = (state_q == S_SEND) ? shift_q[7:0] : 8'd0;
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_FIN);
    err_o          = err_q;
  end

endmodule
